mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single unified memory port between the instruction-fetch requester and the load/store (data) requester. Sequences each access through a fixed-latency access window, drives `w_enable` for exactly one cycle per store, and returns registered read data. Sits between the pipeline's IF/MEM stages and the byte-addressed memory, whose read path is combinational and whose writes commit on `posedge clk`.

## Interface
- `MEM_LATENCY`, 1: cycles the memory port is held per access (legal 1..15).
- `STARVE_LIMIT`, 4: consecutive data grants tolerated while fetch waits (used only with the guard, see Configuration).
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `if_req` input 1: fetch request; held until `if_gnt`.
- `if_addr` input 32: fetch address.
- `if_gnt` output 1: one-cycle grant pulse.
- `if_rvalid` output 1: one-cycle response pulse.
- `if_rdata` output 32: fetched word, valid with `if_rvalid`.
- `d_req` input 1: data request; held with its fields until `d_gnt`.
- `d_addr` input 32: data address.
- `d_wdata` input 32: store data.
- `d_we` input 1: 1 = store, 0 = load.
- `d_size` input 2: access size (BYTE/HALFWORD/WORD encoding).
- `d_rdun` input 1: unsigned load.
- `d_gnt` output 1: one-cycle grant pulse.
- `d_rvalid` output 1: one-cycle completion pulse (loads and stores).
- `d_rdata` output 32: load data, valid with `d_rvalid`.
- `mem_address` output 32; `mem_data_in` output 32; `mem_w_enable` output 1; `mem_access_size` output 2; `mem_RdUn` output 1: memory port drive.
- `mem_data_out` input 32: memory read data (combinational).

## Operation
- States: IDLE, ACCESS, RESP.
- Arbitration runs in IDLE and RESP. Data beats fetch unless the starvation guard forces fetch. On winning edge: latch owner, address, wdata, we, size, rdun; load `cnt = MEM_LATENCY-1`; go to ACCESS.
- Fetch is latched as WORD, `RdUn=0`, `we=0`.
- ACCESS: `mem_*` driven from the latched registers. `mem_w_enable = latched_we && cnt==0`, so each store is written exactly once. If `cnt!=0`, decrement. If `cnt==0`, capture `mem_data_out` into the owner's rdata register (loads only; store leaves rdata unchanged), then go to RESP.
- The owner's gnt is registered and is high during the first ACCESS cycle only.
- RESP: the owner's rvalid is high for one cycle. If a request is pending, arbitrate and go directly to ACCESS; otherwise go to IDLE.
- Outside ACCESS: `mem_w_enable=0`, `mem_address=0`, `mem_data_in=0`, `mem_access_size=WORD`, `mem_RdUn=0`.
- The arbiter performs no range or alignment check. Out-of-range reads return whatever the memory supplies.
- A requester must deassert req in the cycle after its gnt unless issuing a new request. A req still high after gnt is treated as a new request.

## Timing
- Reset values: state IDLE; all gnt/rvalid 0; `if_rdata` and `d_rdata` 0; `mem_w_enable` 0; `cnt` 0; starvation counter 0.
- Reset mid-access aborts the access. A store with `cnt>0` is never written, and no rvalid is issued.
- Latency: req sampled at edge k in IDLE → gnt in cycle k+1 → rvalid in cycle k+1+MEM_LATENCY.
- Back-to-back throughput: one access per MEM_LATENCY+1 cycles.
- Simultaneous `if_req` and `d_req`: data wins (subject to the guard). The loser keeps req high and is served next.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each data grant issued while `if_req` is high.
  - It clears on any fetch grant, and whenever a data grant is issued with `if_req` low.
  - When it equals `STARVE_LIMIT`, the next arbitration grants fetch even if `d_req` is high.
- `ARB_STARVE_GUARD_EN` undefined: strict data priority; no counter is built.

## Test plan
- Single fetch, MEM_LATENCY=1, `if_addr=0x01000000`, memory word 0x00000013 → `if_gnt` in cycle 1, `if_rvalid` in cycle 2, `if_rdata=0x00000013`.
- Byte store then signed byte load at 0x01000100, MEM_LATENCY=3, `d_wdata=0x000000F0` → exactly one `mem_w_enable` cycle; load returns 0xFFFFFFF0; same load with `d_rdun=1` returns 0x000000F0.
- `if_req` and `d_req` asserted together → `d_gnt` first; `if_gnt` in the RESP cycle's following ACCESS; no idle cycle between the two accesses.
- With `ARB_STARVE_GUARD_EN`, STARVE_LIMIT=4, `d_req` continuously high and `if_req` high → 4 data grants, then 1 fetch grant, then data resumes.
- Without the macro, same stimulus → fetch is never granted while `d_req` stays high.
- `reset` asserted in the first ACCESS cycle of a store with MEM_LATENCY=3 → memory byte unchanged, no rvalid, state IDLE, all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and load/store, holding each
// access for MEM_LATENCY cycles. Define ARB_STARVE_GUARD_EN to bound how long fetch can starve.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_rdun,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    output logic [1:0]  mem_access_size,
    output logic        mem_RdUn,
    input  logic [31:0] mem_data_out
);
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [3:0] CNT_LOAD  = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        owner_d_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        rdun_reg;
    logic        if_gnt_reg;
    logic        d_gnt_reg;
    logic        if_rvalid_reg;
    logic        d_rvalid_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] d_rdata_reg;

    logic arb_phase;
    logic force_fetch;
    logic grant_d;
    logic grant_if;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_reg;

    assign force_fetch = if_req && (starve_reg == 4'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_reg <= '0;
        end else if (grant_if) begin
            starve_reg <= '0;
        end else if (grant_d) begin
            starve_reg <= if_req ? starve_reg + 4'd1 : 4'd0;
        end
    end
`else
    // Strict data priority: fetch is never forced, STARVE_LIMIT has no effect.
    assign force_fetch = (STARVE_LIMIT < 0);
`endif

    assign arb_phase = (state_reg == IDLE) || (state_reg == RESP);
    assign grant_d   = arb_phase && d_req && !force_fetch;
    assign grant_if  = arb_phase && if_req && !grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            owner_d_reg   <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            size_reg      <= SIZE_WORD;
            rdun_reg      <= 1'b0;
            if_gnt_reg    <= 1'b0;
            d_gnt_reg     <= 1'b0;
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
        end else begin
            if_gnt_reg    <= 1'b0;
            d_gnt_reg     <= 1'b0;
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            case (state_reg)
                IDLE, RESP: begin
                    if (grant_d) begin
                        state_reg   <= ACCESS;
                        cnt_reg     <= CNT_LOAD;
                        owner_d_reg <= 1'b1;
                        addr_reg    <= d_addr;
                        wdata_reg   <= d_wdata;
                        we_reg      <= d_we;
                        size_reg    <= d_size;
                        rdun_reg    <= d_rdun;
                        d_gnt_reg   <= 1'b1;
                    end else if (grant_if) begin
                        state_reg   <= ACCESS;
                        cnt_reg     <= CNT_LOAD;
                        owner_d_reg <= 1'b0;
                        addr_reg    <= if_addr;
                        wdata_reg   <= '0;
                        we_reg      <= 1'b0;
                        size_reg    <= SIZE_WORD;
                        rdun_reg    <= 1'b0;
                        if_gnt_reg  <= 1'b1;
                    end else begin
                        state_reg   <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= RESP;
                        if (owner_d_reg) begin
                            d_rvalid_reg <= 1'b1;
                            if (!we_reg) begin
                                d_rdata_reg <= mem_data_out;
                            end
                        end else begin
                            if_rvalid_reg <= 1'b1;
                            if_rdata_reg  <= mem_data_out;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign if_gnt    = if_gnt_reg;
    assign d_gnt     = d_gnt_reg;
    assign if_rvalid = if_rvalid_reg;
    assign d_rvalid  = d_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

    // Port is parked at a harmless word read whenever no access is in flight.
    always_comb begin
        mem_address     = '0;
        mem_data_in     = '0;
        mem_w_enable    = 1'b0;
        mem_access_size = SIZE_WORD;
        mem_RdUn        = 1'b0;
        if (state_reg == ACCESS) begin
            mem_address     = addr_reg;
            mem_data_in     = wdata_reg;
            mem_w_enable    = we_reg && (cnt_reg == 4'd0);
            mem_access_size = size_reg;
            mem_RdUn        = rdun_reg;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (latency 1) and instance B (latency 3),
// each with its own byte-addressed memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_rdun, a_d_gnt, a_d_rvalid;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [1:0]  a_d_size, a_mem_access_size;
    logic [31:0] a_mem_address, a_mem_data_in, a_mem_data_out;
    logic        a_mem_w_enable, a_mem_RdUn;

    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_rdun, b_d_gnt, b_d_rvalid;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [1:0]  b_d_size, b_mem_access_size;
    logic [31:0] b_mem_address, b_mem_data_in, b_mem_data_out;
    logic        b_mem_w_enable, b_mem_RdUn;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
        .if_rdata(a_if_rdata), .d_req(a_d_req), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_we(a_d_we), .d_size(a_d_size), .d_rdun(a_d_rdun), .d_gnt(a_d_gnt),
        .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata), .mem_address(a_mem_address),
        .mem_data_in(a_mem_data_in), .mem_w_enable(a_mem_w_enable),
        .mem_access_size(a_mem_access_size), .mem_RdUn(a_mem_RdUn), .mem_data_out(a_mem_data_out)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .d_req(b_d_req), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_we(b_d_we), .d_size(b_d_size), .d_rdun(b_d_rdun), .d_gnt(b_d_gnt),
        .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .mem_address(b_mem_address),
        .mem_data_in(b_mem_data_in), .mem_w_enable(b_mem_w_enable),
        .mem_access_size(b_mem_access_size), .mem_RdUn(b_mem_RdUn), .mem_data_out(b_mem_data_out)
    );

    // Memory models: combinational read with sign/zero extension, writes on posedge
    logic [7:0]  mem_a [0:4095];
    logic [7:0]  mem_b [0:4095];
    logic        pk_we = 1'b0;
    logic        pk_sel = 1'b0;
    logic [11:0] pk_addr = '0;
    logic [31:0] pk_data = '0;
    logic [11:0] a_idx, b_idx;
    assign a_idx = a_mem_address[11:0];
    assign b_idx = b_mem_address[11:0];

    function automatic logic [31:0] mem_rd(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [1:0] size, input logic rdun);
        case (size)
            2'd0:    return rdun ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'd1:    return rdun ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    assign a_mem_data_out = mem_rd(mem_a[a_idx], mem_a[a_idx + 12'd1], mem_a[a_idx + 12'd2],
                                   mem_a[a_idx + 12'd3], a_mem_access_size, a_mem_RdUn);
    assign b_mem_data_out = mem_rd(mem_b[b_idx], mem_b[b_idx + 12'd1], mem_b[b_idx + 12'd2],
                                   mem_b[b_idx + 12'd3], b_mem_access_size, b_mem_RdUn);

    always @(posedge clk) begin
        if (pk_we && !pk_sel) begin
            mem_a[pk_addr] <= pk_data[7:0];
            mem_a[pk_addr + 12'd1] <= pk_data[15:8];
            mem_a[pk_addr + 12'd2] <= pk_data[23:16];
            mem_a[pk_addr + 12'd3] <= pk_data[31:24];
        end else if (a_mem_w_enable) begin
            mem_a[a_idx] <= a_mem_data_in[7:0];
            if (a_mem_access_size != 2'd0) mem_a[a_idx + 12'd1] <= a_mem_data_in[15:8];
            if (a_mem_access_size == 2'd2) begin
                mem_a[a_idx + 12'd2] <= a_mem_data_in[23:16];
                mem_a[a_idx + 12'd3] <= a_mem_data_in[31:24];
            end
        end
    end

    always @(posedge clk) begin
        if (pk_we && pk_sel) begin
            mem_b[pk_addr] <= pk_data[7:0];
            mem_b[pk_addr + 12'd1] <= pk_data[15:8];
            mem_b[pk_addr + 12'd2] <= pk_data[23:16];
            mem_b[pk_addr + 12'd3] <= pk_data[31:24];
        end else if (b_mem_w_enable) begin
            mem_b[b_idx] <= b_mem_data_in[7:0];
            if (b_mem_access_size != 2'd0) mem_b[b_idx + 12'd1] <= b_mem_data_in[15:8];
            if (b_mem_access_size == 2'd2) begin
                mem_b[b_idx + 12'd2] <= b_mem_data_in[23:16];
                mem_b[b_idx + 12'd3] <= b_mem_data_in[31:24];
            end
        end
    end

    task automatic poke(input logic sel, input logic [11:0] addr, input logic [31:0] data);
        pk_sel = sel; pk_addr = addr; pk_data = data; pk_we = 1'b1;
        @(posedge clk); #1;
        pk_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_if_req = 0; a_d_req = 0; b_if_req = 0; b_d_req = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One data access on instance B; cycle numbers count sampled cycles after req is raised
    task automatic b_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic rdun,
                            output int gnt_c, output int rv_c, output int wen_c, output int wen_n,
                            output logic [31:0] wen_addr, output logic [31:0] wen_data,
                            output logic [31:0] rdata);
        gnt_c = -1; rv_c = -1; wen_c = -1; wen_n = 0; wen_addr = '0; wen_data = '0; rdata = '0;
        b_d_we = we; b_d_addr = addr; b_d_wdata = wdata; b_d_size = size; b_d_rdun = rdun;
        b_d_req = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (b_d_gnt && gnt_c < 0) begin gnt_c = cyc; b_d_req = 1'b0; end
            if (b_mem_w_enable) begin
                wen_n++; wen_c = cyc; wen_addr = b_mem_address; wen_data = b_mem_data_in;
            end
            if (b_d_rvalid) begin rv_c = cyc; rdata = b_d_rdata; break; end
        end
        b_d_req = 1'b0;
        $display("txn B we=%0d addr=%h size=%0d rdun=%0d gnt@%0d rvalid@%0d rdata=%h",
                 we, addr, size, rdun, gnt_c, rv_c, rdata);
    endtask

    task automatic test_reset();
        checks++; if (a_if_gnt !== 1'b0) $display("FAIL rst_if_gnt got=%b exp=0", a_if_gnt); else passed++;
        checks++; if (a_d_gnt !== 1'b0) $display("FAIL rst_d_gnt got=%b exp=0", a_d_gnt); else passed++;
        checks++; if (a_if_rvalid !== 1'b0) $display("FAIL rst_if_rvalid got=%b exp=0", a_if_rvalid); else passed++;
        checks++; if (a_d_rvalid !== 1'b0) $display("FAIL rst_d_rvalid got=%b exp=0", a_d_rvalid); else passed++;
        checks++; if (a_if_rdata !== 32'h0) $display("FAIL rst_if_rdata got=%h exp=0", a_if_rdata); else passed++;
        checks++; if (b_d_rdata !== 32'h0) $display("FAIL rst_d_rdata got=%h exp=0", b_d_rdata); else passed++;
        checks++; if (a_mem_w_enable !== 1'b0) $display("FAIL rst_wen got=%b exp=0", a_mem_w_enable); else passed++;
        checks++; if (a_mem_address !== 32'h0) $display("FAIL rst_addr got=%h exp=0", a_mem_address); else passed++;
        checks++; if (a_mem_access_size !== 2'd2) $display("FAIL rst_size got=%0d exp=2", a_mem_access_size); else passed++;
        $display("txn reset-state checked");
    endtask

    task automatic test_fetch();
        int gnt_c = -1;
        int rv_c = -1;
        logic [31:0] rdata = '0;
        logic [31:0] acc_addr = '0;
        a_if_addr = 32'h0100_0000;
        a_if_req = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (a_if_gnt && gnt_c < 0) begin gnt_c = cyc; acc_addr = a_mem_address; a_if_req = 1'b0; end
            if (a_if_rvalid) begin rv_c = cyc; rdata = a_if_rdata; break; end
        end
        a_if_req = 1'b0;
        $display("txn A fetch addr=%h gnt@%0d rvalid@%0d rdata=%h", a_if_addr, gnt_c, rv_c, rdata);
        checks++; if (gnt_c !== 1) $display("FAIL fetch_gnt_cycle got=%0d exp=1", gnt_c); else passed++;
        checks++; if (rv_c !== 2) $display("FAIL fetch_rvalid_cycle got=%0d exp=2", rv_c); else passed++;
        checks++; if (rdata !== 32'h0000_0013) $display("FAIL fetch_rdata got=%h exp=00000013", rdata); else passed++;
        checks++; if (acc_addr !== 32'h0100_0000) $display("FAIL fetch_mem_addr got=%h exp=01000000", acc_addr); else passed++;
        @(posedge clk); #1;
        checks++; if (a_if_rvalid !== 1'b0) $display("FAIL fetch_rvalid_pulse got=%b exp=0", a_if_rvalid); else passed++;
    endtask

    task automatic test_store_load();
        int gnt_c, rv_c, wen_c, wen_n;
        logic [31:0] wen_addr, wen_data, rdata;
        b_access(1'b1, 32'h0100_0100, 32'h0000_00F0, 2'd0, 1'b0, gnt_c, rv_c, wen_c, wen_n, wen_addr, wen_data, rdata);
        checks++; if (gnt_c !== 1) $display("FAIL st_gnt_cycle got=%0d exp=1", gnt_c); else passed++;
        checks++; if (wen_n !== 1) $display("FAIL st_wen_count got=%0d exp=1", wen_n); else passed++;
        checks++; if (wen_c !== 3) $display("FAIL st_wen_cycle got=%0d exp=3", wen_c); else passed++;
        checks++; if (wen_addr !== 32'h0100_0100) $display("FAIL st_wen_addr got=%h exp=01000100", wen_addr); else passed++;
        checks++; if (wen_data !== 32'h0000_00F0) $display("FAIL st_wen_data got=%h exp=000000f0", wen_data); else passed++;
        checks++; if (rv_c !== 4) $display("FAIL st_rvalid_cycle got=%0d exp=4", rv_c); else passed++;
        checks++; if (rdata !== 32'h0) $display("FAIL st_rdata_kept got=%h exp=0", rdata); else passed++;
        checks++; if (mem_b[12'h100] !== 8'hF0) $display("FAIL st_mem_byte got=%h exp=f0", mem_b[12'h100]); else passed++;

        b_access(1'b0, 32'h0100_0100, 32'h0, 2'd0, 1'b0, gnt_c, rv_c, wen_c, wen_n, wen_addr, wen_data, rdata);
        checks++; if (rv_c !== 4) $display("FAIL lb_rvalid_cycle got=%0d exp=4", rv_c); else passed++;
        checks++; if (wen_n !== 0) $display("FAIL lb_wen_count got=%0d exp=0", wen_n); else passed++;
        checks++; if (rdata !== 32'hFFFF_FFF0) $display("FAIL lb_rdata got=%h exp=fffffff0", rdata); else passed++;

        b_access(1'b0, 32'h0100_0100, 32'h0, 2'd0, 1'b1, gnt_c, rv_c, wen_c, wen_n, wen_addr, wen_data, rdata);
        checks++; if (rdata !== 32'h0000_00F0) $display("FAIL lbu_rdata got=%h exp=000000f0", rdata); else passed++;
    endtask

    task automatic test_reset_mid_access();
        int gnt_c = -1;
        logic bad = 1'b0;
        poke(1'b1, 12'h104, 32'h0000_005A);
        b_d_we = 1'b1; b_d_addr = 32'h0100_0104; b_d_wdata = 32'h0000_00A5; b_d_size = 2'd0; b_d_rdun = 1'b0;
        b_d_req = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (b_d_gnt) begin gnt_c = cyc; break; end
        end
        checks++; if (gnt_c !== 1) $display("FAIL rma_gnt_cycle got=%0d exp=1", gnt_c); else passed++;
        reset = 1'b1;
        b_d_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (b_d_gnt !== 1'b0) $display("FAIL rma_gnt got=%b exp=0", b_d_gnt); else passed++;
        checks++; if (b_d_rdata !== 32'h0) $display("FAIL rma_rdata got=%h exp=0", b_d_rdata); else passed++;
        checks++; if (b_mem_address !== 32'h0) $display("FAIL rma_addr got=%h exp=0", b_mem_address); else passed++;
        checks++; if (b_mem_access_size !== 2'd2) $display("FAIL rma_size got=%0d exp=2", b_mem_access_size); else passed++;
        reset = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (b_d_rvalid || b_mem_w_enable || b_d_gnt) bad = 1'b1;
            @(posedge clk); #1;
        end
        $display("txn B store aborted by reset, byte now %h", mem_b[12'h104]);
        checks++; if (bad !== 1'b0) $display("FAIL rma_quiet got=%b exp=0", bad); else passed++;
        checks++; if (mem_b[12'h104] !== 8'h5A) $display("FAIL rma_mem_byte got=%h exp=5a", mem_b[12'h104]); else passed++;
    endtask

    task automatic test_arbitration();
        int dg = -1, dr = -1, ig = -1, ir = -1;
        logic [31:0] d_data = '0, i_data = '0;
        a_if_addr = 32'h0100_0000;
        a_d_addr = 32'h0100_0004; a_d_we = 1'b0; a_d_size = 2'd2; a_d_rdun = 1'b0; a_d_wdata = '0;
        a_if_req = 1'b1; a_d_req = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (a_d_gnt && dg < 0) begin dg = cyc; a_d_req = 1'b0; end
            if (a_if_gnt && ig < 0) begin ig = cyc; a_if_req = 1'b0; end
            if (a_d_rvalid && dr < 0) begin dr = cyc; d_data = a_d_rdata; end
            if (a_if_rvalid) begin ir = cyc; i_data = a_if_rdata; break; end
        end
        a_if_req = 1'b0; a_d_req = 1'b0;
        $display("txn A both: d_gnt@%0d d_rvalid@%0d if_gnt@%0d if_rvalid@%0d", dg, dr, ig, ir);
        checks++; if (dg !== 1) $display("FAIL arb_d_gnt got=%0d exp=1", dg); else passed++;
        checks++; if (dr !== 2) $display("FAIL arb_d_rvalid got=%0d exp=2", dr); else passed++;
        checks++; if (ig !== 3) $display("FAIL arb_if_gnt got=%0d exp=3", ig); else passed++;
        checks++; if (ir !== 4) $display("FAIL arb_if_rvalid got=%0d exp=4", ir); else passed++;
        checks++; if (d_data !== 32'hDEAD_BEEF) $display("FAIL arb_d_rdata got=%h exp=deadbeef", d_data); else passed++;
        checks++; if (i_data !== 32'h0000_0013) $display("FAIL arb_if_rdata got=%h exp=00000013", i_data); else passed++;
    endtask

    task automatic test_starvation();
        logic [7:0] seq [7];
        logic [7:0] exp_seq [7];
        int n = 0;
`ifdef ARB_STARVE_GUARD_EN
        exp_seq = '{"D", "D", "D", "D", "F", "D", "D"};
`else
        exp_seq = '{"D", "D", "D", "D", "D", "D", "D"};
`endif
        for (int i = 0; i < 7; i++) seq[i] = "-";
        do_reset();
        a_if_addr = 32'h0100_0000;
        a_d_addr = 32'h0100_0004; a_d_we = 1'b0; a_d_size = 2'd2; a_d_rdun = 1'b0;
        a_d_req = 1'b1; a_if_req = 1'b1;
        for (int cyc = 1; cyc <= 40 && n < 7; cyc++) begin
            @(posedge clk); #1;
            if (a_d_gnt) begin seq[n] = "D"; n++; end
            else if (a_if_gnt) begin seq[n] = "F"; n++; a_if_req = 1'b0; end
        end
        a_d_req = 1'b0; a_if_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("txn A starvation grants: %c%c%c%c%c%c%c", seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6]);
        checks++; if (n !== 7) $display("FAIL starve_grant_count got=%0d exp=7", n); else passed++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i]) $display("FAIL starve_grant_%0d got=%c exp=%c", i, seq[i], exp_seq[i]);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_addr = '0; a_d_wdata = '0;
        a_d_we = 0; a_d_size = 2'd2; a_d_rdun = 0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_addr = '0; b_d_wdata = '0;
        b_d_we = 0; b_d_size = 2'd2; b_d_rdun = 0;
        do_reset();
        poke(1'b0, 12'h000, 32'h0000_0013);
        poke(1'b0, 12'h004, 32'hDEAD_BEEF);
        test_reset();
        test_fetch();
        test_store_load();
        test_reset_mid_access();
        test_arbitration();
        test_starvation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
